// File: rtl/pu_io_pkg.sv
// Shared definitions for the processing-unit I/O space: register offsets,
// STATUS bit positions and the packet type.
package pu_io_pkg;

    localparam int PKT_W_DEFAULT = 10;

    localparam int REG_DATA   = 0;
    localparam int REG_STATUS = 1;
    localparam int REG_CTRL   = 2;

    localparam int ST_RX_EMPTY = 0;
    localparam int ST_RX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_TX_FULL  = 3;
    localparam int ST_RX_UNF   = 4;
    localparam int ST_TX_OVF   = 5;
    localparam int ST_RX_CNT   = 8;
    localparam int ST_TX_CNT   = 12;

    typedef logic [PKT_W_DEFAULT-1:0] pkt_t;

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous packet FIFO with occupancy count; push and pop may share a cycle,
// and a push into a full FIFO is taken only when a pop frees the slot.
module pkt_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [3:0]   count,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    assign empty  = (r_cnt == '0);
    assign full   = (r_cnt == CW'(DEPTH));
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);
    assign count  = 4'(r_cnt);
    // Empty head reads as zero so an idle TX port presents tx_pkt = 0.
    assign dout   = empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= din;
    end

endmodule

// File: rtl/pu_nic_ctrl.sv
// Memory-mapped NIC packet controller: RX/TX FIFOs, STATUS with sticky errors,
// and optional CTRL/irq enabled by defining PU_NIC_IRQ_EN.
module pu_nic_ctrl
    import pu_io_pkg::*;
#(
    parameter int PKT_W      = PKT_W_DEFAULT,
    parameter int DW         = 16,
    parameter int AW         = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [AW-1:0]    ad,
    input  logic             we,
    input  logic             re,
    input  logic [DW-1:0]    wd,
    output logic [DW-1:0]    rd,
    input  logic [PKT_W-1:0] rx_pkt,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [PKT_W-1:0] tx_pkt,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             irq
);

    logic             r_rdy;
    logic             r_rx_unf;
    logic             r_tx_ovf;
    logic             w_data_sel;
    logic             w_stat_sel;
    logic             w_ctrl_sel;
    logic             w_rx_push;
    logic             w_rx_pop;
    logic             w_tx_push;
    logic             w_tx_pop;
    logic             w_unf_set;
    logic             w_ovf_set;
    logic [PKT_W-1:0] w_rx_head;
    logic [3:0]       w_rx_cnt;
    logic [3:0]       w_tx_cnt;
    logic             w_rx_full;
    logic             w_rx_empty;
    logic             w_tx_full;
    logic             w_tx_empty;
    logic [15:0]      w_status;
    logic [DW-1:0]    w_ctrl_rd;
    logic             w_unused;

    assign w_data_sel = sel && (ad == AW'(REG_DATA));
    assign w_stat_sel = sel && (ad == AW'(REG_STATUS));
    assign w_ctrl_sel = sel && (ad == AW'(REG_CTRL));

    // rx_ready is held low through reset and rises on the first edge after release.
    assign rx_ready  = r_rdy & ~w_rx_full;
    assign w_rx_push = rx_valid & rx_ready;
    assign w_rx_pop  = w_data_sel & re;
    assign w_unf_set = w_rx_pop & w_rx_empty;

    assign tx_valid  = ~w_tx_empty;
    assign w_tx_pop  = tx_valid & tx_ready;
    assign w_tx_push = w_data_sel & we;
    assign w_ovf_set = w_tx_push & w_tx_full & ~w_tx_pop;

    assign w_unused = &{1'b0, wd[DW-1:PKT_W]};

    pkt_fifo #(.W(PKT_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(w_rx_push), .pop(w_rx_pop), .din(rx_pkt),
        .dout(w_rx_head), .count(w_rx_cnt), .full(w_rx_full), .empty(w_rx_empty)
    );

    pkt_fifo #(.W(PKT_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(w_tx_push), .pop(w_tx_pop), .din(wd[PKT_W-1:0]),
        .dout(tx_pkt), .count(w_tx_cnt), .full(w_tx_full), .empty(w_tx_empty)
    );

    // A new error event outranks a same-cycle W1C of the same flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy    <= 1'b0;
            r_rx_unf <= 1'b0;
            r_tx_ovf <= 1'b0;
        end else begin
            r_rdy    <= 1'b1;
            r_rx_unf <= w_unf_set | (r_rx_unf & ~(w_stat_sel & we & wd[ST_RX_UNF]));
            r_tx_ovf <= w_ovf_set | (r_tx_ovf & ~(w_stat_sel & we & wd[ST_TX_OVF]));
        end
    end

`ifdef PU_NIC_IRQ_EN
    logic [1:0] r_ctrl;
    logic       r_irq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl <= 2'b00;
            r_irq  <= 1'b0;
        end else begin
            if (w_ctrl_sel && we) r_ctrl <= wd[1:0];
            r_irq <= (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & w_tx_empty) | r_rx_unf | r_tx_ovf;
        end
    end

    assign irq       = r_irq;
    assign w_ctrl_rd = DW'(r_ctrl);
`else
    assign irq       = 1'b0;
    assign w_ctrl_rd = '0;
`endif

    always_comb begin
        w_status                   = '0;
        w_status[ST_RX_EMPTY]      = w_rx_empty;
        w_status[ST_RX_FULL]       = w_rx_full;
        w_status[ST_TX_EMPTY]      = w_tx_empty;
        w_status[ST_TX_FULL]       = w_tx_full;
        w_status[ST_RX_UNF]        = r_rx_unf;
        w_status[ST_TX_OVF]        = r_tx_ovf;
        w_status[ST_RX_CNT +: 4]   = w_rx_cnt;
        w_status[ST_TX_CNT +: 4]   = w_tx_cnt;
    end

    always_comb begin
        rd = '0;
        if (w_data_sel)      rd = DW'(w_rx_head);
        else if (w_stat_sel) rd = DW'(w_status);
        else if (w_ctrl_sel) rd = w_ctrl_rd;
    end

endmodule

// File: doc/pu_nic_ctrl.md
# pu_nic_ctrl

Memory-mapped packet I/O controller between the processing unit's data-memory I/O space and the NIC. It sequences 10-bit packet transfers in both directions through small RX/TX FIFOs. Each side uses a valid/ready handshake, so the CPU never drops a packet silently. It exposes status, sticky error flags and an optional interrupt. It decodes the I/O half of the data address space, the half where the address MSB is 1, in place of the bare pass-through packet registers.

## Interface
Parameters:
- `PKT_W`, 10, packet width.
- `DW`, 16, CPU data width.
- `AW`, 7, I/O offset width (address bits below the I/O-select MSB).
- `FIFO_DEPTH`, 4, entries per FIFO. Power of two, 2..8.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `sel` in 1: I/O space selected (data address MSB).
- `ad` in AW: I/O register offset.
- `we` in 1: CPU write strobe.
- `re` in 1: CPU read strobe. Pops RX on a DATA read.
- `wd` in DW: CPU write data.
- `rd` out DW: CPU read data. Combinational.
- `rx_pkt` in PKT_W: NIC→CPU packet.
- `rx_valid` in 1: NIC offers `rx_pkt`.
- `rx_ready` out 1: controller accepts RX.
- `tx_pkt` out PKT_W: CPU→NIC packet (TX FIFO head).
- `tx_valid` out 1: TX packet available.
- `tx_ready` in 1: NIC accepts TX.
- `irq` out 1: interrupt request, level.

## Operation
Register map (offsets in `ad`, valid only when `sel`=1):
- 0x00 DATA.
  - Read returns {0, RX head}.
  - `re` pops the RX head.
  - A write pushes `wd[PKT_W-1:0]` into TX.
- 0x01 STATUS, read-only except W1C bits.
  - [0] rx_empty, [1] rx_full, [2] tx_empty, [3] tx_full.
  - [4] rx_unf, sticky. [5] tx_ovf, sticky.
  - [11:8] rx_count, [15:12] tx_count.
  - Writing 1 to bit 4 or bit 5 clears that flag.
- 0x02 CTRL, R/W, only with IRQ compiled in.
  - [0] irq on RX non-empty.
  - [1] irq on TX empty.
- Other offsets read 0; writes to them are ignored. `rd`=0 when `sel`=0. Nothing acts unless `sel`=1.

FIFO and handshake rules:
- RX side.
  - `rx_ready` = !rx_full.
  - An RX push happens when `rx_valid`&&`rx_ready`.
- TX side.
  - `tx_valid` = !tx_empty and `tx_pkt` = TX head.
  - A TX pop happens when `tx_valid`&&`tx_ready`.
  - `tx_pkt` is held stable while `tx_valid`&&!`tx_ready`.
- DATA read with RX empty: returns 0, no pop, sets rx_unf.
- DATA write with TX full: the packet is dropped and tx_ovf is set. Exception: if the NIC pops TX in the same cycle, the write is accepted and the count is unchanged.
- RX full blocks the NIC, so there is no RX overflow.
- Simultaneous events in one cycle are legal, and each FIFO's count is updated by push minus pop:
  - CPU pop and NIC push on RX.
  - CPU push and NIC pop on TX.
  - CPU DATA read and write together.
- W1C and a new error event in the same cycle: the flag ends set (set wins).
- Pointers wrap modulo FIFO_DEPTH; a count of FIFO_DEPTH means full.

## Timing
- All state (FIFOs, pointers, counts, sticky flags, CTRL) updates on posedge `clk`.
- `rd` is combinational from current state, consistent with the combinational data-memory read. A read-with-pop returns the pre-pop head.
- Latencies:
  - NIC RX push → visible in DATA/STATUS the next cycle.
  - CPU TX write → `tx_valid` the next cycle.
  - Earliest RX-to-TX loopback is 2 cycles.
- Reset values:
  - `rx_ready`=0 while `rst` is high, 1 from the first cycle after release.
  - `tx_valid`=0, `tx_pkt`=0, `irq`=0.
  - FIFOs empty, counts 0, sticky flags 0, CTRL 0.
  - STATUS reads 0x0005.
- Reset mid-transfer flushes both FIFOs immediately (asynchronous). `tx_valid` drops without handshake, and the NIC must discard it.
- `irq` is registered and asserts the cycle after its condition becomes true.

## Configuration
- `PU_NIC_IRQ_EN` defined:
  - CTRL register present.
  - `irq` = (ctrl[0]&!rx_empty) | (ctrl[1]&tx_empty) | rx_unf | tx_ovf.
- Undefined:
  - `irq` tied 0.
  - CTRL reads 0; writes to it are ignored.
  - No CTRL flops.

## Structure
- Shared package `pu_io_pkg`:
  - Register offset constants (DATA=0x00, STATUS=0x01, CTRL=0x02).
  - STATUS bit-position constants.
  - PKT_W default.
  - Packet typedef `pkt_t`.
- Sub-module `pkt_fifo` (synchronous FIFO with count/full/empty, pop-and-push same cycle) is instantiated twice, for RX and TX.
- `pu_nic_ctrl` holds the address decode, sticky flags, CTRL and the irq flop.

## Test plan
- Reset, then read STATUS → 0x0005, `rx_ready`=1, `tx_valid`=0, `irq`=0.
- NIC pushes 0x155, 0x2AA.
  - STATUS → rx_count=2.
  - Two DATA reads → 0x0155, 0x02AA.
  - Third read → 0, rx_unf=1.
  - Write 0x0010 to STATUS clears rx_unf.
- Five DATA writes 0x001..0x005 with `tx_ready`=0:
  - After four writes tx_full=1.
  - The fifth write sets tx_ovf.
  - Raising `tx_ready` drains 0x001..0x004 in order, one per cycle.
- TX full, CPU writes 0x3FF in the same cycle as a NIC pop:
  - Write accepted, tx_count stays 4, tx_ovf stays 0.
  - 0x3FF emerges last.
- RX filled to 4 → `rx_ready`=0.
  - CPU pop in a cycle with `rx_valid`=1 → no push that cycle.
  - Push accepted next cycle, count 4 again.
- With `PU_NIC_IRQ_EN`:
  - CTRL=0x1 plus one RX push → `irq`=1 the next cycle; pop → `irq`=0.
  - `rst` asserted mid-drain → `tx_valid`=0 immediately.
